// File: rtl/dpcpu_pipe_pkg.sv
// rtl/dpcpu_pipe_pkg.sv - ID/EXE pipeline state encodings, bubble constants and control bundle
package dpcpu_pipe_pkg;

  localparam logic [1:0] RUN    = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] SQUASH = 2'd2;

  localparam logic [3:0] ALUC_NOP = 4'd0;
  localparam logic [4:0] RN_ZERO  = 5'd0;

  typedef struct packed {
    logic       wreg;
    logic       reg2reg;
    logic       wmem;
    logic       aluqb;
    logic [3:0] aluc;
    logic [4:0] rn;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Only the architecturally visible side effects are killed; Rn=0 hides the bubble from hazard logic.
  function automatic ctrl_t bubble(input ctrl_t c);
    ctrl_t b;
    b         = c;
    b.wreg    = 1'b0;
    b.reg2reg = 1'b0;
    b.wmem    = 1'b0;
    b.rn      = RN_ZERO;
    return b;
  endfunction

endpackage

// File: rtl/stall_watchdog.sv
// rtl/stall_watchdog.sv - consecutive-stall run counter with sticky overrun flag
module stall_watchdog
  import dpcpu_pipe_pkg::*;
#(
  parameter int MAX_STALL = 4
) (
  input  logic       Clk,
  input  logic       Clrn,
  input  logic       stall,
  input  logic       flush,
  input  logic [1:0] state,
  output logic       stall_err
);

  localparam logic [3:0] MAX_S = 4'(MAX_STALL);

  logic [3:0] scnt;
  logic       stall_run;

  assign stall_run = stall & ~flush;

  // A run only continues from HOLD; entering a stall from RUN/SQUASH starts a new run.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      scnt      <= 4'd0;
      stall_err <= 1'b0;
    end else if (stall_run) begin
      if (scnt >= MAX_S) stall_err <= 1'b1;
      if (state != HOLD)      scnt <= 4'd1;
      else if (scnt != 4'd15) scnt <= scnt + 4'd1;
    end else begin
      scnt <= 4'd0;
    end
  end

endmodule

// File: rtl/id_exe_bubble_reg.sv
// rtl/id_exe_bubble_reg.sv - ID/EXE register with stall bubble, flush squash and watchdog (option: STALL_PERF_CNT_EN)
module id_exe_bubble_reg
  import dpcpu_pipe_pkg::*;
#(
  parameter int DW        = 32,
  parameter int MAX_STALL = 4
) (
  input  logic          Clk,
  input  logic          Clrn,
  input  logic          stall,
  input  logic          flush,
  input  logic          D_Wreg,
  input  logic          D_Reg2reg,
  input  logic          D_Wmem,
  input  logic          D_Aluqb,
  input  logic [3:0]    D_Aluc,
  input  logic [4:0]    D_Rn,
  input  logic [DW-1:0] D_Qa,
  input  logic [DW-1:0] D_Qb,
  input  logic [DW-1:0] D_Ext,
  output logic          E_Wreg,
  output logic          E_Reg2reg,
  output logic          E_Wmem,
  output logic          E_Aluqb,
  output logic [3:0]    E_Aluc,
  output logic [4:0]    E_Rn,
  output logic [DW-1:0] E_Qa,
  output logic [DW-1:0] E_Qb,
  output logic [DW-1:0] E_Ext,
  output logic          PC_en,
  output logic          IFID_en,
  output logic          IFID_clr,
  output logic          stall_err
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]   perf_stall,
  output logic [31:0]   perf_flush
`endif
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  ctrl_t      d_ctrl;
  ctrl_t      e_ctrl;
  logic       inject;

  assign d_ctrl   = ctrl_t'({D_Wreg, D_Reg2reg, D_Wmem, D_Aluqb, D_Aluc, D_Rn});
  assign inject   = stall | flush;

  // A flush must let the redirected fetch proceed, so it overrides the stall's hold.
  assign PC_en    = flush | ~stall;
  assign IFID_en  = flush | ~stall;
  assign IFID_clr = flush;

  always_comb begin
    state_nxt = RUN;
    if (flush)      state_nxt = SQUASH;
    else if (stall) state_nxt = HOLD;
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state  <= RUN;
      e_ctrl <= '0;
      E_Qa   <= '0;
      E_Qb   <= '0;
      E_Ext  <= '0;
    end else begin
      state  <= state_nxt;
      e_ctrl <= inject ? bubble(d_ctrl) : d_ctrl;
      E_Qa   <= D_Qa;
      E_Qb   <= D_Qb;
      E_Ext  <= D_Ext;
    end
  end

  assign E_Wreg    = e_ctrl.wreg;
  assign E_Reg2reg = e_ctrl.reg2reg;
  assign E_Wmem    = e_ctrl.wmem;
  assign E_Aluqb   = e_ctrl.aluqb;
  assign E_Aluc    = e_ctrl.aluc;
  assign E_Rn      = e_ctrl.rn;

  stall_watchdog #(.MAX_STALL(MAX_STALL)) u_wd (
    .Clk       (Clk),
    .Clrn      (Clrn),
    .stall     (stall),
    .flush     (flush),
    .state     (state),
    .stall_err (stall_err)
  );

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      perf_stall <= 32'd0;
      perf_flush <= 32'd0;
    end else begin
      if (flush)      perf_flush <= perf_flush + 32'd1;
      else if (stall) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_exe_bubble_reg.sv
// tb/tb_id_exe_bubble_reg.sv - randomized self-checking bench for id_exe_bubble_reg
module tb_id_exe_bubble_reg;

  localparam int DW = 32;
  localparam int MAXS = 4;

  logic          Clk = 1'b0;
  logic          Clrn = 1'b0;
  logic          stall = 1'b0, flush = 1'b0;
  logic          D_Wreg = 1'b0, D_Reg2reg = 1'b0, D_Wmem = 1'b0, D_Aluqb = 1'b0;
  logic [3:0]    D_Aluc = '0;
  logic [4:0]    D_Rn = '0;
  logic [DW-1:0] D_Qa = '0, D_Qb = '0, D_Ext = '0;
  logic          E_Wreg, E_Reg2reg, E_Wmem, E_Aluqb;
  logic [3:0]    E_Aluc;
  logic [4:0]    E_Rn;
  logic [DW-1:0] E_Qa, E_Qb, E_Ext;
  logic          PC_en, IFID_en, IFID_clr, stall_err;
`ifdef STALL_PERF_CNT_EN
  logic [31:0]   perf_stall, perf_flush;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  id_exe_bubble_reg #(.DW(DW), .MAX_STALL(MAXS)) dut (
    .Clk(Clk), .Clrn(Clrn), .stall(stall), .flush(flush),
    .D_Wreg(D_Wreg), .D_Reg2reg(D_Reg2reg), .D_Wmem(D_Wmem), .D_Aluqb(D_Aluqb),
    .D_Aluc(D_Aluc), .D_Rn(D_Rn), .D_Qa(D_Qa), .D_Qb(D_Qb), .D_Ext(D_Ext),
    .E_Wreg(E_Wreg), .E_Reg2reg(E_Reg2reg), .E_Wmem(E_Wmem), .E_Aluqb(E_Aluqb),
    .E_Aluc(E_Aluc), .E_Rn(E_Rn), .E_Qa(E_Qa), .E_Qb(E_Qb), .E_Ext(E_Ext),
    .PC_en(PC_en), .IFID_en(IFID_en), .IFID_clr(IFID_clr), .stall_err(stall_err)
`ifdef STALL_PERF_CNT_EN
    , .perf_stall(perf_stall), .perf_flush(perf_flush)
`endif
  );

  function automatic logic [108:0] e_vec();
    return {E_Wreg, E_Reg2reg, E_Wmem, E_Aluqb, E_Aluc, E_Rn, E_Qa, E_Qb, E_Ext};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    stall = 1'b0; flush = 1'b0;
    Clrn = 1'b0;
    tick();
    Clrn = 1'b1;
    #1;
  endtask

  task automatic rand_d();
    {D_Wreg, D_Reg2reg, D_Wmem, D_Aluqb} = 4'($urandom);
    D_Aluc = 4'($urandom);
    D_Rn   = 5'($urandom);
    D_Qa   = $urandom; D_Qb = $urandom; D_Ext = $urandom;
  endtask

  task automatic test_reset();
    do_reset();
    D_Wreg = 1'b1; D_Rn = 5'd9; D_Qa = 32'h1234_5678;
    tick();
    Clrn = 1'b0;
    #1;
    n_cmp++;
    if (e_vec() !== '0) begin
      n_bad++; $display("FAIL reset_async_e got=%h exp=0", e_vec());
    end
    n_cmp++;
    if (stall_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_stall_err got=%b exp=0", stall_err);
    end
    tick();
    Clrn = 1'b1;
    #1;
    n_cmp++;
    if (dut.state !== 2'd0 || PC_en !== 1'b1) begin
      n_bad++; $display("FAIL reset_release state=%0d pc_en=%b exp state=0 pc_en=1", dut.state, PC_en);
    end
  endtask

  task automatic test_normal();
    D_Wreg = 1'b1; D_Reg2reg = 1'b0; D_Wmem = 1'b0; D_Aluqb = 1'b0; D_Aluc = 4'd2;
    D_Rn = 5'd7; D_Qa = 32'hA5A5_A5A5; D_Qb = 32'd1; D_Ext = 32'd2;
    #1;
    n_cmp++;
    if ({PC_en, IFID_en, IFID_clr} !== 3'b110) begin
      n_bad++; $display("FAIL normal_enables got=%b exp=110", {PC_en, IFID_en, IFID_clr});
    end
    tick();
    n_cmp++;
    if (E_Rn !== 5'd7 || E_Wreg !== 1'b1 || E_Qa !== 32'hA5A5_A5A5) begin
      n_bad++; $display("FAIL normal_load rn=%0d wreg=%b qa=%h exp 7 1 a5a5a5a5", E_Rn, E_Wreg, E_Qa);
    end
  endtask

  task automatic test_single_stall();
    D_Wreg = 1'b1; D_Wmem = 1'b1; D_Rn = 5'd3; stall = 1'b1;
    #1;
    n_cmp++;
    if (PC_en !== 1'b0 || IFID_en !== 1'b0 || IFID_clr !== 1'b0) begin
      n_bad++; $display("FAIL stall_enables got=%b%b%b exp=000", PC_en, IFID_en, IFID_clr);
    end
    tick();
    n_cmp++;
    if (E_Wreg !== 1'b0 || E_Rn !== 5'd0 || E_Wmem !== 1'b0) begin
      n_bad++; $display("FAIL stall_bubble wreg=%b wmem=%b rn=%0d exp 0 0 0", E_Wreg, E_Wmem, E_Rn);
    end
    stall = 1'b0;
    tick();
    n_cmp++;
    if (E_Rn !== 5'd3 || E_Wreg !== 1'b1 || dut.state !== 2'd0) begin
      n_bad++; $display("FAIL stall_reload rn=%0d wreg=%b state=%0d exp 3 1 0", E_Rn, E_Wreg, dut.state);
    end
  endtask

  task automatic test_flush_stall();
    D_Wreg = 1'b1; D_Rn = 5'd12; stall = 1'b1; flush = 1'b1;
    #1;
    n_cmp++;
    if (IFID_clr !== 1'b1 || PC_en !== 1'b1 || IFID_en !== 1'b1) begin
      n_bad++; $display("FAIL flush_enables clr=%b pc=%b ifid=%b exp 1 1 1", IFID_clr, PC_en, IFID_en);
    end
    tick();
    n_cmp++;
    if (E_Wreg !== 1'b0 || E_Rn !== 5'd0 || dut.state !== 2'd2 || dut.u_wd.scnt !== 4'd0) begin
      n_bad++; $display("FAIL flush_bubble wreg=%b rn=%0d state=%0d scnt=%0d exp 0 0 2 0",
                        E_Wreg, E_Rn, dut.state, dut.u_wd.scnt);
    end
    stall = 1'b0; flush = 1'b0;
    #1;
    n_cmp++;
    if (IFID_clr !== 1'b0) begin
      n_bad++; $display("FAIL squash_clr got=%b exp=0", IFID_clr);
    end
    tick();
    n_cmp++;
    if (dut.state !== 2'd0 || E_Rn !== 5'd12) begin
      n_bad++; $display("FAIL squash_exit state=%0d rn=%0d exp 0 12", dut.state, E_Rn);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    stall = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_cmp++;
      if (stall_err !== (k >= MAXS + 1)) begin
        n_bad++; $display("FAIL wd_edge%0d got=%b exp=%b", k, stall_err, (k >= MAXS + 1));
      end
    end
    stall = 1'b0;
    tick(); tick();
    n_cmp++;
    if (stall_err !== 1'b1 || PC_en !== 1'b1) begin
      n_bad++; $display("FAIL wd_sticky err=%b pc_en=%b exp 1 1", stall_err, PC_en);
    end
    Clrn = 1'b0;
    #1;
    n_cmp++;
    if (stall_err !== 1'b0) begin
      n_bad++; $display("FAIL wd_clear got=%b exp=0", stall_err);
    end
    Clrn = 1'b1;
    #1;
  endtask

  task automatic test_random();
    logic [108:0] exp_e;
    int run;
    logic exp_err;
    do_reset();
    run = 0; exp_err = 1'b0;
    for (int i = 0; i < 300; i++) begin
      rand_d();
      stall = ($urandom_range(0, 99) < 35);
      flush = ($urandom_range(0, 99) < 10);
      #1;
      n_cmp++;
      if ({PC_en, IFID_en, IFID_clr} !== {flush || !stall, flush || !stall, flush}) begin
        n_bad++; $display("FAIL rand_enables[%0d] got=%b stall=%b flush=%b", i,
                          {PC_en, IFID_en, IFID_clr}, stall, flush);
      end
      if (stall || flush)
        exp_e = {1'b0, 1'b0, 1'b0, D_Aluqb, D_Aluc, 5'd0, D_Qa, D_Qb, D_Ext};
      else
        exp_e = {D_Wreg, D_Reg2reg, D_Wmem, D_Aluqb, D_Aluc, D_Rn, D_Qa, D_Qb, D_Ext};
      if (stall && !flush) begin
        if (run >= MAXS) exp_err = 1'b1;
        run = (run < 15) ? run + 1 : 15;
      end else begin
        run = 0;
      end
      tick();
      n_cmp++;
      if (e_vec() !== exp_e) begin
        n_bad++; $display("FAIL rand_e[%0d] got=%h exp=%h", i, e_vec(), exp_e);
      end
      n_cmp++;
      if (stall_err !== exp_err) begin
        n_bad++; $display("FAIL rand_err[%0d] got=%b exp=%b", i, stall_err, exp_err);
      end
    end
    stall = 1'b0; flush = 1'b0;
  endtask

`ifdef STALL_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1; tick(); stall = 1'b0; tick();
    end
    for (int k = 0; k < 2; k++) begin
      flush = 1'b1; stall = (k == 0); tick(); flush = 1'b0; stall = 1'b0; tick();
    end
    n_cmp++;
    if (perf_stall !== 32'd3 || perf_flush !== 32'd2) begin
      n_bad++; $display("FAIL perf_counts stall=%0d flush=%0d exp 3 2", perf_stall, perf_flush);
    end
    force dut.perf_stall = 32'hFFFF_FFFF;
    #1;
    release dut.perf_stall;
    stall = 1'b1; tick(); stall = 1'b0;
    n_cmp++;
    if (perf_stall !== 32'd0) begin
      n_bad++; $display("FAIL perf_wrap got=%h exp=0", perf_stall);
    end
  endtask
`endif

  initial begin
    #2;
    test_reset();
    test_normal();
    test_single_stall();
    test_flush_stall();
    test_watchdog();
    test_random();
`ifdef STALL_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_exe_bubble_reg.md
Name: id_exe_bubble_reg

Overview:
- ID/EXE pipeline register for the 5-stage DPCPU; it is the responder to the hazard-detect `stall` and branch `flush` requests.
- On a stall it holds PC and IF/ID and injects a bubble into EXE, so E_Wreg=0 and E_Wmem=0.
- On a flush it squashes IF/ID and ID/EXE.
- It also tracks the stall run length with a watchdog.

Parameters:
- DW, 32, datapath width of Qa/Qb/Ext.
- MAX_STALL, 4, maximum consecutive stall cycles before `stall_err` asserts; legal range 1..15.

Ports:
- Clk  in  1  rising-edge clock.
- Clrn  in  1  asynchronous active-low reset.
- stall  in  1  load-use hazard request from the ID-stage detector.
- flush  in  1  taken-branch squash request from the EXE/MEM resolution.
- D_Wreg, D_Reg2reg, D_Wmem, D_Aluqb  in  1 each  ID-stage control bits.
- D_Aluc  in  4  ALU op.
- D_Rn  in  5  destination register.
- D_Qa, D_Qb, D_Ext  in  DW each  operands and immediate.
- E_Wreg, E_Reg2reg, E_Wmem, E_Aluqb, E_Aluc, E_Rn, E_Qa, E_Qb, E_Ext  out  same widths  registered EXE-stage copies.
- PC_en  out  1  PC write enable (combinational).
- IFID_en  out  1  IF/ID write enable (combinational).
- IFID_clr  out  1  IF/ID synchronous clear request (combinational).
- stall_err  out  1  sticky watchdog flag.

Behaviour:
- Reset (Clrn=0, asynchronous):
  - All E_* outputs go to 0, which is a NOP bubble.
  - FSM goes to RUN, stall counter scnt=0, stall_err=0.
- FSM states RUN, HOLD, SQUASH; 2-bit state, one update per Clk edge.
- Priority each cycle: flush > stall > normal.
- RUN, flush=0, stall=0:
  - E_* <= D_* on the edge.
  - PC_en=1, IFID_en=1, IFID_clr=0.
- Any state, stall=1 and flush=0:
  - PC_en=0, IFID_en=0, IFID_clr=0.
  - On the edge E_Wreg<=0, E_Wmem<=0, E_Reg2reg<=0, E_Rn<=0. All other E_* fields load D_* (don't-care but deterministic).
  - Next state HOLD; scnt <= scnt+1, saturating at 15.
- HOLD, stall=0 and flush=0:
  - Normal load; next state RUN; scnt <= 0.
- Any state, flush=1:
  - PC_en=1, IFID_en=1, IFID_clr=1.
  - E_* <= bubble (same fields zeroed as for a stall).
  - Next state SQUASH; scnt <= 0. A stall in the same cycle is discarded.
- SQUASH:
  - Lasts exactly 1 cycle; IFID_clr=0.
  - Loads normally unless stall/flush applies.
  - Next state RUN, or HOLD if stall=1.
- Watchdog:
  - When scnt reaches MAX_STALL and stall is still 1, stall_err <= 1.
  - stall_err is sticky until Clrn.
  - The stall itself is still honoured; the watchdog never forces progress.
- Latency:
  - D_* to E_* is 1 cycle.
  - The bubble is visible on E_* in the cycle after stall is sampled.
  - PC_en, IFID_en and IFID_clr are combinational from stall/flush/state; there is no register delay.
- An E_Rn=0 bubble guarantees the downstream hazard detector sees no write (its R0 exclusion).

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_stall[31:0] and perf_flush[31:0].
  - Counters increment on each edge where a stall (resp. flush) bubble is injected, wrap at 2^32, and reset to 0 on Clrn.
- When undefined:
  - Ports and logic are absent.
  - Core behaviour is identical.

Decomposition:
- Package dpcpu_pipe_pkg holds:
  - State encodings RUN=2'd0, HOLD=2'd1, SQUASH=2'd2.
  - NOP bubble constants (ALUC_NOP=4'd0, RN_ZERO=5'd0).
  - The ctrl-bundle width.
- One natural sub-module: stall_watchdog, holding scnt, the saturation logic and stall_err, driven by stall/flush/state.
- The register bank and FSM stay in the top module.

Test Plan:
- Reset:
  - Stimulus: Clrn=0 mid-run with D_Wreg=1.
  - Response: all E_*=0 immediately (asynchronous); stall_err=0; after release, state=RUN, PC_en=1.
- Normal flow:
  - Stimulus: D_Rn=5'd7, D_Wreg=1, D_Qa=32'hA5A5A5A5, no stall.
  - Response: next edge E_Rn=7, E_Wreg=1, E_Qa=A5A5A5A5.
- Single stall:
  - Stimulus: stall=1 for one cycle with D_Wreg=1, D_Rn=3.
  - Response: PC_en=0 and IFID_en=0 that cycle; next edge E_Wreg=0, E_Rn=0; the following cycle reloads D_Rn=3.
- Flush + stall together:
  - Stimulus: flush=1 and stall=1 in the same cycle.
  - Response: IFID_clr=1, PC_en=1, bubble on E_*, state=SQUASH, scnt=0.
- Watchdog:
  - Stimulus: MAX_STALL=4, stall held 6 cycles.
  - Response: stall_err rises on the 5th held edge and stays 1 after stall drops, until Clrn.
- Perf counters (STALL_PERF_CNT_EN):
  - Stimulus: 3 stall bubbles and 2 flushes.
  - Response: perf_stall=3, perf_flush=2; preload 32'hFFFFFFFF, then one stall → perf_stall wraps to 0.
